pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It gates the write enables and bubble inserts of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Arbitrates three hazard sources by fixed priority: multi-cycle data-memory access (handshake FSM), load-use, and taken branch resolved in ID.
- Keeps a saturating stall-cycle performance counter and a sticky memory-timeout error.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/hazard_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: memory handshake FSM states
// and the architectural zero register index.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds a source of the
// instruction in ID; writes to x0 never create a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  output logic       load_use
);

  assign load_use = idex_mem_read && (idex_rd != REG_ZERO) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory handshake FSM,
// fixed-priority hazard arbitration and stall-cycle/timeout bookkeeping.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic [4:0]       IFID_Rs1_i,
  input  logic [4:0]       IFID_Rs2_i,
  input  logic             Branch_taken_i,
  input  logic             EXMEM_MemAcc_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             EXMEMWrite_o,
  output logic             MEMWBBubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  mem_state_e        state_reg, state_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              load_use;
  logic              mem_stall;
  logic              lu_stall;
  logic              br_flush;

  hazard_detect u_hazard_detect (
    .idex_mem_read (IDEX_MemRead_i),
    .idex_rd       (IDEX_Rd_i),
    .ifid_rs1      (IFID_Rs1_i),
    .ifid_rs2      (IFID_Rs2_i),
    .load_use      (load_use)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      to_cnt_reg  <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      to_cnt_reg  <= to_cnt_next;
      mem_err_reg <= mem_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    to_cnt_next  = to_cnt_reg;
    mem_err_next = mem_err_reg;
    case (state_reg)
      IDLE: if (EXMEM_MemAcc_i) state_next = REQ;
      REQ: begin
        to_cnt_next = '0;
        state_next  = mem_ack_i ? DONE : WAIT;
      end
      WAIT: begin
        to_cnt_next = to_cnt_reg + 1'b1;
        if (mem_ack_i) begin
          state_next = DONE;
        end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
          mem_err_next = 1'b1;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hazards are masked while reset is held so the pipeline sees free-run values.
  assign mem_stall = !rst_i && ((state_reg == IDLE && EXMEM_MemAcc_i) ||
                                state_reg == REQ || state_reg == WAIT);
  assign lu_stall  = !rst_i && !mem_stall && load_use;
  assign br_flush  = !rst_i && !mem_stall && !load_use && Branch_taken_i;

  always_comb begin
    PCWrite_o     = 1'b1;
    IFIDWrite_o   = 1'b1;
    IFIDFlush_o   = 1'b0;
    IDEXBubble_o  = 1'b0;
    EXMEMWrite_o  = 1'b1;
    MEMWBBubble_o = 1'b0;
    if (mem_stall) begin
      PCWrite_o     = 1'b0;
      IFIDWrite_o   = 1'b0;
      EXMEMWrite_o  = 1'b0;
      MEMWBBubble_o = 1'b1;
    end else if (lu_stall) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXBubble_o = 1'b1;
    end else if (br_flush) begin
      IFIDFlush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if ((mem_stall || lu_stall) && stall_cnt_reg != '1) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign mem_req_o      = (state_reg == REQ);
  assign mem_err_o      = mem_err_reg;
  assign stall_cycles_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued as
// each cycle is driven and compared against the DUT at the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  // ctrl order: {mem_req, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, EXMEMWrite, MEMWBBubble}
  localparam logic [6:0] C_NONE = 7'b0110010;
  localparam logic [6:0] C_BR   = 7'b0111010;
  localparam logic [6:0] C_LU   = 7'b0000110;
  localparam logic [6:0] C_MS   = 7'b0000001;
  localparam logic [6:0] C_MSR  = 7'b1000001;

  typedef struct packed {
    logic [6:0]       ctrl;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             idex_memread;
  logic [4:0]       idex_rd, ifid_rs1, ifid_rs2;
  logic             br_taken, exmem_macc, mem_ack;
  logic             mem_req, pc_write, ifid_write, ifid_flush;
  logic             idex_bubble, exmem_write, memwb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  exp_t             sb_q[$];
  int               checks = 0;
  int               errors = 0;
  int               exp_cnt = 0;
  int               step_no = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .TO_W(8), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (idex_memread),
    .IDEX_Rd_i      (idex_rd),
    .IFID_Rs1_i     (ifid_rs1),
    .IFID_Rs2_i     (ifid_rs2),
    .Branch_taken_i (br_taken),
    .EXMEM_MemAcc_i (exmem_macc),
    .mem_ack_i      (mem_ack),
    .mem_req_o      (mem_req),
    .PCWrite_o      (pc_write),
    .IFIDWrite_o    (ifid_write),
    .IFIDFlush_o    (ifid_flush),
    .IDEXBubble_o   (idex_bubble),
    .EXMEMWrite_o   (exmem_write),
    .MEMWBBubble_o  (memwb_bubble),
    .mem_err_o      (mem_err),
    .stall_cycles_o (stall_cycles)
  );

  task automatic push_exp(input logic [6:0] ctrl, input logic err);
    exp_t e;
    e.ctrl = ctrl;
    e.err  = err;
    e.cnt  = CNT_W'(exp_cnt);
    sb_q.push_back(e);
    if (ctrl == C_LU || ctrl == C_MS || ctrl == C_MSR) exp_cnt++;
  endtask

  task automatic pop_cmp(input string tag);
    exp_t       e;
    logic [6:0] obs;
    e   = sb_q.pop_front();
    obs = {mem_req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_bubble};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, obs, e.ctrl);
    end
    checks++;
    assert (mem_err === e.err) else begin
      errors++;
      $error("FAIL %s mem_err: observed %b expected %b", tag, mem_err, e.err);
    end
    checks++;
    assert (stall_cycles === e.cnt) else begin
      errors++;
      $error("FAIL %s stall_cycles: observed %0d expected %0d", tag, stall_cycles, e.cnt);
    end
    $display("step %0d %s ctrl=%b err=%b stall=%0d", step_no, tag, obs, mem_err, stall_cycles);
    step_no++;
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic step(input string tag, input logic mrd, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                      input logic macc, input logic ack,
                      input logic [6:0] ectrl, input logic eerr);
    idex_memread = mrd;
    idex_rd      = rd;
    ifid_rs1     = rs1;
    ifid_rs2     = rs2;
    br_taken     = br;
    exmem_macc   = macc;
    mem_ack      = ack;
    push_exp(ectrl, eerr);
    @(negedge clk);
    pop_cmp(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs2 = 5'd0;
    br_taken = 1'b1; exmem_macc = 1'b1; mem_ack = 1'b0;
    // Hazard inputs active during reset must not leak to the outputs.
    push_exp(C_NONE, 1'b0);
    exp_cnt = 0;
    @(negedge clk);
    pop_cmp("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("idle",       0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);
    step("lu_rs2",     1, 5'd5, 5'd1, 5'd5, 0, 0, 0, C_LU,   0);
    step("after_lu",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);
    step("lu_rd0",     1, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);
    step("lu_rs1",     1, 5'd7, 5'd7, 5'd2, 0, 0, 0, C_LU,   0);
    step("branch",     0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_BR,   0);

    step("m3_idle",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   0);
    step("m3_req",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MSR,  0);
    step("m3_wait1",   0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   0);
    step("m3_wait2",   0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_MS,   0);
    step("m3_done",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);
    step("m3_after",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);

    step("ar_idle",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   0);
    step("ar_req_ack", 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_MSR,  0);
    step("ar_done",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);
    step("stray_ack",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_NONE, 0);

    step("all_idle",   1, 5'd3, 5'd3, 5'd0, 1, 1, 0, C_MS,   0);
    step("all_req",    1, 5'd3, 5'd3, 5'd0, 1, 1, 0, C_MSR,  0);
    step("all_wait",   1, 5'd3, 5'd3, 5'd0, 1, 1, 1, C_MS,   0);
    step("all_lu",     1, 5'd3, 5'd3, 5'd0, 1, 0, 0, C_LU,   0);
    step("all_br",     0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_BR,   0);

    step("to_idle",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   0);
    step("to_req",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MSR,  0);
    for (int i = 0; i < 4; i++)
      step("to_wait",  0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   0);
    step("to_done",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 1);
    step("err_idle",   0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   1);
    step("err_req",    0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_MSR,  1);
    step("err_done",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 1);

    step("rw_idle",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   1);
    step("rw_req",     0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MSR,  1);
    step("rw_wait",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MS,   1);
    // Still in WAIT: assert reset between clock edges and look immediately.
    exmem_macc = 1'b1;
    #2;
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    push_exp(C_NONE, 1'b0);
    pop_cmp("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);
    step("post_lu",    1, 5'd9, 5'd9, 5'd0, 0, 0, 0, C_LU,   0);
    step("post_cnt",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
